// File: rtl/video_pkg.sv
// video_pkg: shared constants for the video frame fetch path.
// Holds the SPI flash opcodes, the flash address width, the FSM state
// encoding and the frame address helper. The FAST_READ_EN macro (seen by
// spi_frame_fetch) selects which opcode is used and enables the DUMMY state.
package video_pkg;

    localparam int ADDR_W     = 24;
    localparam int DUMMY_BITS = 8;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_CMD   = 3'd2;
    localparam state_t ST_ADDR  = 3'd3;
    localparam state_t ST_DUMMY = 3'd4;
    localparam state_t ST_DATA  = 3'd5;
    localparam state_t ST_STOP  = 3'd6;

    // Byte address of a frame; frames are packed back to back, the
    // product is truncated to the flash address width.
    function automatic logic [ADDR_W-1:0] frame_addr(input logic [31:0] idx,
                                                     input int          bytes);
        return ADDR_W'(idx * 32'(bytes));
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: parallel-load, MSB-first shift register with serial capture.
// The MSB feeds MOSI while the command/address goes out; during data the
// same register shifts MISO in at the LSB, so cap is the newest bit.
// No configuration macros.
import video_pkg::*;

module spi_shift_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift,
    input  logic         din,
    output logic         dout,
    output logic         cap
);

    logic [W-1:0] sr_q, sr_d;

    // load has priority; a shift moves toward the MSB and pulls din in
    always_comb begin
        sr_d = sr_q;
        if (load)
            sr_d = load_val;
        else if (shift)
            sr_d = {sr_q[W-2:0], din};
    end

    // register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sr_q <= '0;
        else
            sr_q <= sr_d;
    end

    assign dout = sr_q[W-1];
    assign cap  = sr_q[0];

endmodule

// File: rtl/spi_frame_fetch.sv
// spi_frame_fetch: reads one video frame from SPI flash per frame_req.
// Mode-0 SPI master paced by SPI_clk_en (one strobe = one SCLK half-period).
// Sends a read opcode plus a 24-bit frame address, then streams FRAME_BITS
// received bits out as bit_valid/bit_data strobes.
// Macro FAST_READ_EN: opcode 0x0B plus 8 dummy SCLKs before data.
import video_pkg::*;

module spi_frame_fetch #(
    parameter int FRAME_BITS = 48,
    parameter int NUM_FRAMES = 32
) (
    input  logic CLK_40,
    input  logic reset_n,
    input  logic SPI_clk_en,
    input  logic frame_req,
    input  logic MISO,
    output logic CS_n,
    output logic SCLK,
    output logic MOSI,
    output logic bit_valid,
    output logic bit_data,
    output logic busy,
    output logic frame_done
);

    localparam int IDX_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] LAST_CMD   = CNT_W'(7);
    localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] LAST_DUMMY = CNT_W'(DUMMY_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(FRAME_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_FRAMES - 1);

`ifdef FAST_READ_EN
    localparam logic [7:0] OPCODE = CMD_FAST_READ;
`else
    localparam logic [7:0] OPCODE = CMD_READ;
`endif

    state_t            state_q, state_d;
    logic              sclk_q, sclk_d;
    logic              cs_n_q, cs_n_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  phase_last;

    logic sr_load, sr_shift, sr_din, sr_msb, sr_cap;

    spi_shift_reg #(.W(8 + ADDR_W)) u_sr (
        .clk      (CLK_40),
        .rst_n    (reset_n),
        .load     (sr_load),
        .load_val ({OPCODE, frame_addr(32'(idx_q), FRAME_BITS / 8)}),
        .shift    (sr_shift),
        .din      (sr_din),
        .dout     (sr_msb),
        .cap      (sr_cap)
    );

    // next-state logic; only frame_req acceptance ignores the strobe
    always_comb begin
        state_d  = state_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_din   = 1'b0;

        case (state_q)
            ST_CMD:   phase_last = LAST_CMD;
            ST_ADDR:  phase_last = LAST_ADDR;
            ST_DUMMY: phase_last = LAST_DUMMY;
            default:  phase_last = LAST_DATA;
        endcase

        case (state_q)
            ST_IDLE: begin
                // a coincident strobe is deliberately not used here
                if (frame_req) state_d = ST_START;
            end
            ST_START: begin
                if (SPI_clk_en) begin
                    cs_n_d  = 1'b0;
                    sr_load = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_CMD;
                end
            end
`ifdef FAST_READ_EN
            ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
`else
            ST_CMD, ST_ADDR, ST_DATA: begin
`endif
                if (SPI_clk_en) begin
                    if (!sclk_q) begin
                        // rising edge: the flash output is stable, capture it
                        sclk_d = 1'b1;
                        if (state_q == ST_DATA) begin
                            sr_shift = 1'b1;
                            sr_din   = MISO;
                            valid_d  = 1'b1;
                        end
                    end else begin
                        // falling edge: present the next MOSI bit, count the bit
                        sclk_d = 1'b0;
                        if (state_q == ST_CMD || state_q == ST_ADDR)
                            sr_shift = 1'b1;
                        if (cnt_q == phase_last) begin
                            cnt_d = '0;
                            case (state_q)
                                ST_CMD:   state_d = ST_ADDR;
`ifdef FAST_READ_EN
                                ST_ADDR:  state_d = ST_DUMMY;
                                ST_DUMMY: state_d = ST_DATA;
`else
                                ST_ADDR:  state_d = ST_DATA;
`endif
                                default:  state_d = ST_STOP;
                            endcase
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_STOP: begin
                if (SPI_clk_en) begin
                    cs_n_d  = 1'b1;
                    sclk_d  = 1'b0;
                    done_d  = 1'b1;
                    idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // register state; reset aborts any transfer without a frame_done
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    assign CS_n       = cs_n_q;
    assign SCLK       = sclk_q;
    assign MOSI       = (state_q == ST_CMD || state_q == ST_ADDR) & sr_msb;
    assign bit_valid  = valid_q;
    assign bit_data   = valid_q & sr_cap;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done_q;

endmodule

// File: doc/spi_frame_fetch.md
SPI_FRAME_FETCH -- requirements
Module: spi_frame_fetch

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 48, meaning data bits read per frame (X_WIDTH*Y_HEIGHT of the video bank); multiple of 8.
REQ-002 SHALL have parameter NUM_FRAMES, default 32, meaning frames stored in flash before the frame index wraps.
REQ-003 SHALL have port CLK_40 input 1, the 40 MHz system clock; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port reset_n input 1, the asynchronous active-low reset.
REQ-005 SHALL have port SPI_clk_en input 1, a single-cycle strobe from clk_en_gen; each strobe is one SCLK half-period.
REQ-006 SHALL have port frame_req input 1, a single-cycle request to fetch the next frame.
REQ-007 SHALL have port MISO input 1, the flash serial data out.
REQ-008 SHALL have port CS_n output 1, the flash chip select, active-low.
REQ-009 SHALL have port SCLK output 1, the SPI clock, mode 0 (idle low).
REQ-010 SHALL have port MOSI output 1, the command/address serial out, MSB first.
REQ-011 SHALL have port bit_valid output 1, a one-cycle strobe marking a new received bit (drives video_bank_we).
REQ-012 SHALL have port bit_data output 1, the received bit, valid while bit_valid=1.
REQ-013 SHALL have port busy output 1, high from frame_req acceptance until frame_done.
REQ-014 SHALL have port frame_done output 1, a one-cycle strobe at end of frame.

Function
REQ-015 SHALL implement FSM states IDLE, START, CMD, ADDR, (DUMMY), DATA, STOP; all transitions except frame_req acceptance occur only on cycles with SPI_clk_en=1.
REQ-016 IDLE: frame_req=1 SHALL be accepted -> START and busy=1 next cycle; frame_req while busy=1 SHALL be ignored (no queuing).
REQ-017 START, first SPI_clk_en: CS_n->0, MOSI=command bit 7, -> CMD.
REQ-018 In CMD/ADDR/DUMMY/DATA, odd strobes SHALL drive SCLK 0->1 and even strobes 1->0, with MOSI shifting to the next bit on the falling strobe.
REQ-019 CMD SHALL send 8'h03 (read); ADDR SHALL send 24-bit address = frame_idx*(FRAME_BITS/8), truncated to 24 bits.
REQ-020 DATA SHALL sample MISO on each rising strobe and pulse bit_valid with bit_data=sample exactly one CLK_40 cycle later; exactly FRAME_BITS pulses per frame; MOSI=0 in DATA.
REQ-021 After the falling strobe of the last data bit -> STOP; next strobe: CS_n->1, SCLK=0, frame_done=1 for one cycle, busy->0, -> IDLE.
REQ-022 Without the DUMMY phase, strobe count from the START strobe through the STOP strobe inclusive SHALL be 2 + 2*(32+FRAME_BITS) (162 at default).
REQ-023 frame_idx SHALL increment at frame_done and wrap from NUM_FRAMES-1 to 0.
REQ-024 frame_req coincident with SPI_clk_en in IDLE SHALL be accepted; that strobe SHALL NOT advance START.

Reset
REQ-025 reset_n=0 SHALL asynchronously force CS_n=1, SCLK=0, MOSI=0, bit_valid=0, bit_data=0, busy=0, frame_done=0, frame_idx=0, state=IDLE, including mid-transaction; no frame_done on abort.

Configuration
REQ-026 With FAST_READ_EN defined: command 8'h0B and a DUMMY phase of 8 SCLK cycles (MOSI=0, MISO ignored) between ADDR and DATA, adding 16 strobes (178 at default); without it: 8'h03, no DUMMY state.

Structure
REQ-027 Command opcodes, address width (24) and FSM state enum SHALL live in shared package video_pkg.
REQ-028 One sub-module spi_shift_reg (parallel-load, MSB-first shift, serial capture) SHALL be used for CMD/ADDR and DATA.

Verification
REQ-029 Reset release, one frame_req -> MOSI bits 0x03 then 0x000000, 48 bit_valid pulses matching MISO, frame_done after 162 strobes.
REQ-030 Second frame_req -> address 0x000006; 32nd frame -> 0x0000BA; 33rd frame -> 0x000000 (wrap).
REQ-031 frame_req pulsed mid-DATA -> ignored, busy stays 1, bit_valid count still 48.
REQ-032 reset_n=0 at data bit 20 -> CS_n=1 immediately, no frame_done; next request uses address 0x000000.
REQ-033 FAST_READ_EN defined -> opcode 0x0B, 8 idle SCLKs before data, frame_done after 178 strobes.
REQ-034 frame_req coincident with SPI_clk_en -> accepted; CS_n falls on the following strobe, not the same one.
